// File: rtl/lsb_mem_ctrl_pkg.sv
// Shared widths, funct3 encodings and the access-size helper for the LSB memory controller.
package lsb_mem_ctrl_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int VAL_WIDTH    = 32;
    localparam int FUNCT3_WIDTH = 3;
    localparam int LSB_ID_WIDTH = 3;

    typedef logic [FUNCT3_WIDTH-1:0] funct3_t;

    localparam funct3_t FUNCT3_LB  = 3'b000;
    localparam funct3_t FUNCT3_LH  = 3'b001;
    localparam funct3_t FUNCT3_LW  = 3'b010;
    localparam funct3_t FUNCT3_LBU = 3'b100;
    localparam funct3_t FUNCT3_LHU = 3'b101;

    // Only funct3[1:0] carries the size; bit 2 selects zero-extension on loads.
    function automatic logic [2:0] byte_count(input funct3_t funct3);
        case (funct3[1:0])
            2'b00:   byte_count = 3'd1;
            2'b01:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsb_mem_ctrl.sv
// Byte-serial memory controller between the load/store buffer and the byte-wide RAM/IO bus.
// Accesses of 1, 2 or 4 bytes are sequenced little-endian, one byte per cycle.
module lsb_mem_ctrl
    import lsb_mem_ctrl_pkg::*;
#(
    parameter int LSB_ID_W = LSB_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    lsb2mem_load_en,
    input  logic                    lsb2mem_store_en,
    input  logic [ADDR_WIDTH-1:0]   lsb2mem_addr,
    input  logic [FUNCT3_WIDTH-1:0] lsb2mem_type,
    input  logic [VAL_WIDTH-1:0]    lsb2mem_val,
    input  logic [LSB_ID_W-1:0]     lsb2mem_load_id,
    output logic                    mem_busy,
    output logic                    mem2lsb_load_en,
    output logic [VAL_WIDTH-1:0]    mem2lsb_load_val,
    output logic [LSB_ID_W-1:0]     mem2lsb_load_id,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] req_addr;
    funct3_t               req_type;
    logic [VAL_WIDTH-1:0]  req_val;
    logic [LSB_ID_W-1:0]   req_id;
    logic [VAL_WIDTH-1:0]  lanes;

    logic [2:0]            n_bytes;
    logic [2:0]            rd_idx;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  io_stall;
    logic                  capture;
    logic                  last_capture;
    logic [1:0]            cap_lane;
    logic [VAL_WIDTH-1:0]  merged;

    function automatic logic [VAL_WIDTH-1:0] extend_load(input funct3_t funct3,
                                                         input logic [VAL_WIDTH-1:0] raw);
        case (funct3)
            FUNCT3_LB:  extend_load = {{24{raw[7]}}, raw[7:0]};
            FUNCT3_LBU: extend_load = {24'd0, raw[7:0]};
            FUNCT3_LH:  extend_load = {{16{raw[15]}}, raw[15:0]};
            FUNCT3_LHU: extend_load = {16'd0, raw[15:0]};
            FUNCT3_LW:  extend_load = raw;
            default:    extend_load = raw;
        endcase
    endfunction

    assign n_bytes  = byte_count(req_type);
    assign wr_addr  = req_addr + ADDR_WIDTH'(cnt);
    assign io_stall = (wr_addr[17:16] == 2'b11) && io_buffer_full;

    // While frozen, the previous byte address is re-driven so mem_din still holds
    // the byte owed to the pending capture when rdy_in returns.
    assign rd_idx   = (!rdy_in && cnt != 3'd0) ? cnt - 3'd1 : cnt;
    assign rd_addr  = req_addr + ADDR_WIDTH'(rd_idx);

    assign capture      = (state == ST_READ) && (cnt != 3'd0) && (cnt <= n_bytes);
    assign last_capture = (state == ST_READ) && (cnt == n_bytes);
    assign cap_lane     = 2'(cnt - 3'd1);

    assign mem_busy = (state != ST_IDLE);

    // Lanes as they will look after this cycle's capture, used for the response value.
    always_comb begin
        merged = lanes;
        if (capture) begin
            merged[{cap_lane, 3'b000} +: 8] = mem_din;
        end
    end

    // Bus drive is purely a function of state so reset clears it immediately.
    always_comb begin
        mem_a    = '0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        case (state)
            ST_WRITE: begin
                mem_a    = wr_addr;
                mem_dout = req_val[{cnt[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in && !io_stall;
            end
            ST_READ: begin
                if (rd_idx < n_bytes) begin
                    mem_a = rd_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state            <= ST_IDLE;
            cnt              <= 3'd0;
            req_addr         <= '0;
            req_type         <= '0;
            req_val          <= '0;
            req_id           <= '0;
            lanes            <= '0;
            mem2lsb_load_en  <= 1'b0;
            mem2lsb_load_val <= '0;
            mem2lsb_load_id  <= '0;
        end else begin
            // The response strobe is cleared even while frozen so it never stretches.
            mem2lsb_load_en <= 1'b0;
            if (rdy_in) begin
                case (state)
                    ST_IDLE: begin
                        if (!flush && (lsb2mem_store_en || lsb2mem_load_en)) begin
                            state    <= lsb2mem_store_en ? ST_WRITE : ST_READ;
                            cnt      <= 3'd0;
                            req_addr <= lsb2mem_addr;
                            req_type <= lsb2mem_type;
                            req_val  <= lsb2mem_val;
                            req_id   <= lsb2mem_load_id;
                            lanes    <= '0;
                        end
                    end
                    ST_WRITE: begin
                        if (!io_stall) begin
                            if (cnt == n_bytes - 3'd1) begin
                                state <= ST_IDLE;
                                cnt   <= 3'd0;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (flush) begin
                            state <= ST_IDLE;
                            cnt   <= 3'd0;
                        end else begin
                            if (capture) begin
                                lanes <= merged;
                            end
                            if (last_capture) begin
                                mem2lsb_load_en  <= 1'b1;
                                mem2lsb_load_val <= extend_load(req_type, merged);
                                mem2lsb_load_id  <= req_id;
                            end
                            if (cnt == n_bytes + 3'd1) begin
                                state <= ST_IDLE;
                                cnt   <= 3'd0;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Directed self-checking bench for lsb_mem_ctrl with a synchronous byte-RAM model.
module tb_lsb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        load_en_in;
    logic        store_en_in;
    logic [31:0] addr;
    logic [2:0]  ftype;
    logic [31:0] val;
    logic [2:0]  id;
    logic        mem_busy;
    logic        load_en;
    logic [31:0] load_val;
    logic [2:0]  load_id;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:262143];
    int          write_count = 0;
    int          assert_count = 0;
    int          fail_count = 0;

    always #5 clk = ~clk;

    lsb_mem_ctrl #(.LSB_ID_W(3)) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .flush            (flush),
        .lsb2mem_load_en  (load_en_in),
        .lsb2mem_store_en (store_en_in),
        .lsb2mem_addr     (addr),
        .lsb2mem_type     (ftype),
        .lsb2mem_val      (val),
        .lsb2mem_load_id  (id),
        .mem_busy         (mem_busy),
        .mem2lsb_load_en  (load_en),
        .mem2lsb_load_val (load_val),
        .mem2lsb_load_id  (load_id),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .io_buffer_full   (io_buffer_full)
    );

    // Read data appears the cycle after the address; writes are only counted.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) begin
            write_count <= write_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic ld, input logic [31:0] a,
                                 input logic [2:0] t, input logic [31:0] v, input logic [2:0] tag_id);
        store_en_in = st;
        load_en_in  = ld;
        addr        = a;
        ftype       = t;
        val         = v;
        id          = tag_id;
        next_cycle();
        store_en_in = 1'b0;
        load_en_in  = 1'b0;
    endtask

    task automatic run_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] v,
                             input int n, input logic fl, input logic both);
        int wc;
        wc = write_count;
        applyStimulus(1'b1, both, a, t, v, 3'd0);
        flush = fl;
        for (int k = 0; k < n; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            checkOutput("store_a", mem_a, 32'(a + 32'(k)));
            checkOutput("store_dout", 32'(mem_dout), (v >> (8 * k)) & 32'hFF);
            checkOutput("store_wr", 32'(mem_wr), 32'd1);
            checkOutput("store_busy", 32'(mem_busy), 32'd1);
        end
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("store_done_busy", 32'(mem_busy), 32'd0);
        checkOutput("store_done_wr", 32'(mem_wr), 32'd0);
        checkOutput("store_no_resp", 32'(load_en), 32'd0);
        checkOutput("store_count", 32'(write_count - wc), 32'(n));
        next_cycle();
    endtask

    task automatic run_load(input logic [31:0] a, input logic [2:0] t, input logic [2:0] tag_id,
                            input logic [31:0] exp_val, input int lat, input logic poke);
        int wc;
        wc = write_count;
        applyStimulus(1'b0, 1'b1, a, t, 32'd0, tag_id);
        if (poke) begin
            store_en_in = 1'b1;
            addr        = 32'h900;
            ftype       = 3'b010;
            val         = 32'hFFFF_FFFF;
        end
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                next_cycle();
                store_en_in = 1'b0;
            end
            @(negedge clk);
            if (c <= lat - 2) checkOutput("load_a", mem_a, 32'(a + 32'(c) - 32'd1));
            checkOutput("load_wr", 32'(mem_wr), 32'd0);
            checkOutput("load_pulse", 32'(load_en), 32'(c == lat));
        end
        checkOutput("load_val", load_val, exp_val);
        checkOutput("load_id", 32'(load_id), 32'(tag_id));
        next_cycle();
        @(negedge clk);
        checkOutput("load_idle", 32'(mem_busy), 32'd0);
        checkOutput("load_pulse_end", 32'(load_en), 32'd0);
        checkOutput("load_val_hold", load_val, exp_val);
        checkOutput("load_no_write", 32'(write_count - wc), 32'd0);
        next_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_busy"}, 32'(mem_busy), 32'd0);
        checkOutput({tag, "_load_en"}, 32'(load_en), 32'd0);
        checkOutput({tag, "_load_val"}, load_val, 32'd0);
        checkOutput({tag, "_load_id"}, 32'(load_id), 32'd0);
        checkOutput({tag, "_mem_a"}, mem_a, 32'd0);
        checkOutput({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
        checkOutput({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wc;
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        load_en_in = 1'b0; store_en_in = 1'b0;
        addr = '0; ftype = '0; val = '0; id = '0;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h200] = 8'h80;  ram[18'h201] = 8'h7F;
        ram[18'h3FF] = 8'h34;  ram[18'h400] = 8'h92;
        ram[18'h500] = 8'h00;  ram[18'h501] = 8'h80;
        ram[18'h600] = 8'h11;  ram[18'h601] = 8'h22;
        ram[18'h602] = 8'h33;  ram[18'h603] = 8'h44;
        ram[18'h3FFFF] = 8'hAA;
        ram[18'h0] = 8'hBB;    ram[18'h1] = 8'hCC;    ram[18'h2] = 8'hDD;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        rst_in = 1'b0;

        run_store(32'h100, 3'b010, 32'hA1B2C3D4, 4, 1'b0, 1'b0);
        run_load(32'h200, 3'b000, 3'd5, 32'hFFFF_FF80, 3, 1'b0);
        run_load(32'h200, 3'b100, 3'd2, 32'h0000_0080, 3, 1'b0);
        run_load(32'h201, 3'b000, 3'd3, 32'h0000_007F, 3, 1'b0);
        run_load(32'h3FF, 3'b101, 3'd3, 32'h0000_9234, 4, 1'b0);
        run_load(32'h500, 3'b001, 3'd4, 32'hFFFF_8000, 4, 1'b0);
        run_load(32'h600, 3'b010, 3'd6, 32'h4433_2211, 6, 1'b1);
        run_load(32'hFFFF_FFFF, 3'b010, 3'd7, 32'hDDCC_BBAA, 6, 1'b0);

        // Store wins when both requests arrive together.
        run_store(32'h800, 3'b000, 32'h0000_0077, 1, 1'b0, 1'b1);
        // Flush cannot cancel a committed store.
        run_store(32'h700, 3'b010, 32'hDEAD_BEEF, 4, 1'b1, 1'b0);

        // IO stall: three blocked cycles, then exactly one write.
        wc = write_count;
        io_buffer_full = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0003_0000, 3'b000, 32'h0000_005A, 3'd0);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) next_cycle();
            @(negedge clk);
            checkOutput("io_stall_wr", 32'(mem_wr), 32'd0);
            checkOutput("io_stall_busy", 32'(mem_busy), 32'd1);
            checkOutput("io_stall_a", mem_a, 32'h0003_0000);
        end
        next_cycle();
        io_buffer_full = 1'b0;
        @(negedge clk);
        checkOutput("io_release_wr", 32'(mem_wr), 32'd1);
        checkOutput("io_release_dout", 32'(mem_dout), 32'h5A);
        next_cycle();
        @(negedge clk);
        checkOutput("io_done_busy", 32'(mem_busy), 32'd0);
        checkOutput("io_single_write", 32'(write_count - wc), 32'd1);
        next_cycle();

        // Flush in IDLE suppresses acceptance.
        flush = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h600, 3'b010, 32'd0, 3'd1);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_busy", 32'(mem_busy), 32'd0);
        checkOutput("idle_flush_a", mem_a, 32'd0);
        next_cycle();

        // Flush at T+2 of a word load aborts it.
        applyStimulus(1'b0, 1'b1, 32'h600, 3'b010, 32'd0, 3'd6);
        @(negedge clk);
        checkOutput("flush_ld_busy1", 32'(mem_busy), 32'd1);
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_ld_idle", 32'(mem_busy), 32'd0);
        for (int c = 0; c < 6; c++) begin
            checkOutput("flush_ld_no_pulse", 32'(load_en), 32'd0);
            next_cycle();
            @(negedge clk);
        end
        next_cycle();

        // rdy_in low for two cycles mid-load delays the response by two.
        applyStimulus(1'b0, 1'b1, 32'h600, 3'b010, 32'd0, 3'd1);
        next_cycle();
        rdy_in = 1'b0;
        @(negedge clk);
        checkOutput("frozen_wr", 32'(mem_wr), 32'd0);
        checkOutput("frozen_busy", 32'(mem_busy), 32'd1);
        next_cycle();
        @(negedge clk);
        checkOutput("frozen_no_pulse", 32'(load_en), 32'd0);
        next_cycle();
        rdy_in = 1'b1;
        for (int c = 4; c <= 8; c++) begin
            if (c > 4) next_cycle();
            @(negedge clk);
            checkOutput("resume_pulse", 32'(load_en), 32'(c == 8));
        end
        checkOutput("resume_val", load_val, 32'h4433_2211);
        checkOutput("resume_id", 32'(load_id), 32'd1);
        next_cycle();
        @(negedge clk);
        checkOutput("resume_idle", 32'(mem_busy), 32'd0);
        next_cycle();

        // Reset mid-load clears everything at once and nothing follows.
        wc = write_count;
        applyStimulus(1'b0, 1'b1, 32'h600, 3'b010, 32'd0, 3'd4);
        next_cycle();
        rst_in = 1'b1;
        #1;
        check_all_zero("midload_reset");
        next_cycle();
        rst_in = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("post_reset_pulse", 32'(load_en), 32'd0);
            checkOutput("post_reset_busy", 32'(mem_busy), 32'd0);
            next_cycle();
        end
        checkOutput("post_reset_writes", 32'(write_count - wc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
